// File: rtl/mla_ciphertext_pack_if.sv
// Ciphertext word stream from mla_ciphertext_pack to its consumer.
// The master drives data/valid/last; the slave answers with ready.
interface mla_ciphertext_pack_if #(
  parameter int DATA_WIDTH = 12
) ();

  logic [DATA_WIDTH-1:0] ct_data;
  logic                  ct_valid;
  logic                  ct_ready;
  logic                  ct_last;

  modport master (
    output ct_data,
    output ct_valid,
    output ct_last,
    input  ct_ready
  );

  modport slave (
    input  ct_data,
    input  ct_valid,
    input  ct_last,
    output ct_ready
  );

endinterface

// File: rtl/mla_ciphertext_pack.sv
// Captures five signed accumulators, reduces each mod Q bit-serially and streams them out.
// Define MLA_PACK_MSG_EN to add floor(Q/2)*msg_bit to the sum word.
module mla_ciphertext_pack #(
  parameter int DATA_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int Q          = 3329
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ACC_WIDTH-1:0] acc_col1,
  input  logic [ACC_WIDTH-1:0] acc_col2,
  input  logic [ACC_WIDTH-1:0] acc_col3,
  input  logic [ACC_WIDTH-1:0] acc_col4,
  input  logic [ACC_WIDTH-1:0] acc_sum,
  input  logic                 msg_bit,
  mla_ciphertext_pack_if.master ct,
  output logic                 busy
);

  localparam int CNT_W = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
  localparam int REM_W = DATA_WIDTH + 1;
  localparam logic [REM_W-1:0] Q_R    = REM_W'(Q);
  localparam logic [REM_W-1:0] HALF_Q = REM_W'(Q / 2);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(ACC_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    REDUCE,
    FIXUP,
    OUT
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0]   mag_q, mag_d;
  logic                   sign_q, sign_d;
  logic [REM_W-1:0]       rem_q, rem_d;
  logic [ACC_WIDTH-1:0]   acc_q [5];
  logic [ACC_WIDTH-1:0]   acc_d [5];
  logic [DATA_WIDTH-1:0]  ct_data_q, ct_data_d;
  logic                   ct_valid_q, ct_valid_d;
  logic                   ct_last_q, ct_last_d;

  logic [REM_W-1:0]       rem_shift;
  logic [REM_W-1:0]       rem_fix;
  logic [2:0]             idx_next;
  logic [ACC_WIDTH-1:0]   next_word;
  logic                   msg_add;

  // Two's-complement magnitude; the most negative value maps to 2^(ACC_WIDTH-1).
  function automatic logic [ACC_WIDTH-1:0] magnitude(input logic [ACC_WIDTH-1:0] v);
    return v[ACC_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

`ifdef MLA_PACK_MSG_EN
  logic msg_q, msg_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q <= 1'b0;
    end else begin
      msg_q <= msg_d;
    end
  end

  always_comb begin
    msg_d = msg_q;
    if (state_q == IDLE && start) begin
      msg_d = msg_bit;
    end
  end

  assign msg_add = msg_q;
`else
  logic unused_msg_bit;
  assign unused_msg_bit = msg_bit;
  assign msg_add        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      mag_q      <= '0;
      sign_q     <= 1'b0;
      rem_q      <= '0;
      for (int i = 0; i < 5; i++) begin
        acc_q[i] <= '0;
      end
      ct_data_q  <= '0;
      ct_valid_q <= 1'b0;
      ct_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      mag_q      <= mag_d;
      sign_q     <= sign_d;
      rem_q      <= rem_d;
      for (int i = 0; i < 5; i++) begin
        acc_q[i] <= acc_d[i];
      end
      ct_data_q  <= ct_data_d;
      ct_valid_q <= ct_valid_d;
      ct_last_q  <= ct_last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    mag_d      = mag_q;
    sign_d     = sign_q;
    rem_d      = rem_q;
    for (int i = 0; i < 5; i++) begin
      acc_d[i] = acc_q[i];
    end
    ct_data_d  = ct_data_q;
    ct_valid_d = ct_valid_q;
    ct_last_d  = ct_last_q;
    rem_shift  = '0;
    rem_fix    = '0;
    idx_next   = idx_q + 3'd1;
    next_word  = acc_q[4];

    case (idx_next)
      3'd1:    next_word = acc_q[1];
      3'd2:    next_word = acc_q[2];
      3'd3:    next_word = acc_q[3];
      default: next_word = acc_q[4];
    endcase

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d[0] = acc_col1;
          acc_d[1] = acc_col2;
          acc_d[2] = acc_col3;
          acc_d[3] = acc_col4;
          acc_d[4] = acc_sum;
          idx_d    = 3'd0;
          sign_d   = acc_col1[ACC_WIDTH-1];
          mag_d    = magnitude(acc_col1);
          rem_d    = '0;
          cnt_d    = CNT_TOP;
          state_d  = REDUCE;
        end
      end

      // One restoring-division step per cycle, MSB of the magnitude first.
      REDUCE: begin
        rem_shift = {rem_q[REM_W-2:0], mag_q[cnt_q]};
        rem_d     = (rem_shift >= Q_R) ? (rem_shift - Q_R) : rem_shift;
        if (cnt_q == '0) begin
          state_d = FIXUP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      FIXUP: begin
        rem_fix = (sign_q && (rem_q != '0)) ? (Q_R - rem_q) : rem_q;
        if ((idx_q == 3'd4) && msg_add) begin
          rem_fix = rem_fix + HALF_Q;
          if (rem_fix >= Q_R) begin
            rem_fix = rem_fix - Q_R;
          end
        end
        ct_data_d  = rem_fix[DATA_WIDTH-1:0];
        ct_valid_d = 1'b1;
        ct_last_d  = (idx_q == 3'd4);
        state_d    = OUT;
      end

      // The next word's reduction is set up on the same edge as the handshake.
      OUT: begin
        if (ct.ct_ready) begin
          ct_valid_d = 1'b0;
          ct_last_d  = 1'b0;
          if (ct_last_q) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_next;
            sign_d  = next_word[ACC_WIDTH-1];
            mag_d   = magnitude(next_word);
            rem_d   = '0;
            cnt_d   = CNT_TOP;
            state_d = REDUCE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ct.ct_data  = ct_data_q;
  assign ct.ct_valid = ct_valid_q;
  assign ct.ct_last  = ct_last_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_mla_ciphertext_pack.sv
// Directed bench for mla_ciphertext_pack with a mod-Q reference model and stream scoreboard.
// Follows MLA_PACK_MSG_EN so expectations match whichever build is compiled.
module tb_mla_ciphertext_pack;

  localparam int DW = 12;
  localparam int AW = 32;
  localparam int Q  = 3329;
`ifdef MLA_PACK_MSG_EN
  localparam bit MSG_EN = 1'b1;
`else
  localparam bit MSG_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] acc_col1 = '0;
  logic [AW-1:0] acc_col2 = '0;
  logic [AW-1:0] acc_col3 = '0;
  logic [AW-1:0] acc_col4 = '0;
  logic [AW-1:0] acc_sum  = '0;
  logic          msg_bit  = 1'b0;
  logic          busy;

  mla_ciphertext_pack_if #(.DATA_WIDTH(DW)) ct_bus ();

  mla_ciphertext_pack #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .Q         (Q)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .acc_col1(acc_col1),
    .acc_col2(acc_col2),
    .acc_col3(acc_col3),
    .acc_col4(acc_col4),
    .acc_sum (acc_sum),
    .msg_bit (msg_bit),
    .ct      (ct_bus),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_data [$];
  bit exp_last [$];
  int got [$];

  // Signed value mod Q in [0, Q), plus the message offset on the sum word.
  function automatic int model_word(input logic [AW-1:0] v, input bit m, input bit is_sum);
    longint r;
    r = longint'($signed(v)) % longint'(Q);
    if (r < 0) r = r + Q;
    if (is_sum && m && MSG_EN) r = (r + Q / 2) % Q;
    return int'(r);
  endfunction

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Caller is at posedge+2; returns at start edge +2.
  task automatic apply_start(input logic [AW-1:0] c1, c2, c3, c4, s,
                             input bit m, input bit accept);
    acc_col1 = c1; acc_col2 = c2; acc_col3 = c3; acc_col4 = c4; acc_sum = s;
    msg_bit  = m;
    start    = 1'b1;
    if (accept) begin
      exp_data.push_back(model_word(c1, m, 0)); exp_last.push_back(1'b0);
      exp_data.push_back(model_word(c2, m, 0)); exp_last.push_back(1'b0);
      exp_data.push_back(model_word(c3, m, 0)); exp_last.push_back(1'b0);
      exp_data.push_back(model_word(c4, m, 0)); exp_last.push_back(1'b0);
      exp_data.push_back(model_word(s,  m, 1)); exp_last.push_back(1'b1);
    end
    step();
    start    = 1'b0;
    acc_col1 = $urandom; acc_col2 = $urandom; acc_col3 = $urandom;
    acc_col4 = $urandom; acc_sum  = $urandom; msg_bit = 1'($urandom);
  endtask

  task automatic wait_busy_low(output int n);
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (!busy) break;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("[TB] FAIL busy_timeout: busy still 1 after %0d cycles", n);
    end
  endtask

  task automatic wait_got(input int target);
    int i;
    for (i = 0; i < 2000 && got.size() < target; i++) step();
    if (got.size() < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL word_timeout: got %0d words expected %0d", got.size(), target);
    end
  endtask

  // Scoreboard: every accepted word and every stalled cycle is checked at negedge.
  bit             stall_prev = 1'b0;
  logic [DW-1:0]  stall_data = '0;
  logic           stall_last = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("hold_valid", int'(ct_bus.ct_valid), 1);
        check_eq("hold_data", int'(ct_bus.ct_data), int'(stall_data));
        check_eq("hold_last", int'(ct_bus.ct_last), int'(stall_last));
      end
      if (ct_bus.ct_valid && ct_bus.ct_ready) begin
        if (exp_data.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL extra_word: got %0d expected none", ct_bus.ct_data);
        end else begin
          check_eq("word_data", int'(ct_bus.ct_data), exp_data.pop_front());
          check_eq("word_last", int'(ct_bus.ct_last), int'(exp_last.pop_front()));
        end
        got.push_back(int'(ct_bus.ct_data));
      end
      stall_prev = ct_bus.ct_valid && !ct_bus.ct_ready;
      stall_data = ct_bus.ct_data;
      stall_last = ct_bus.ct_last;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int base;
    ct_bus.ct_ready = 1'b1;

    #3;
    check_eq("rst_data", int'(ct_bus.ct_data), 0);
    check_eq("rst_valid", int'(ct_bus.ct_valid), 0);
    check_eq("rst_last", int'(ct_bus.ct_last), 0);
    check_eq("rst_busy", int'(busy), 0);
    repeat (3) step();
    rst = 1'b1;
    step();

    // Basic stream with latency and total-duration checks.
    base = got.size();
    apply_start(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 1'b0, 1'b1);
    check_eq("busy_rise", int'(busy), 1);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (ct_bus.ct_valid) break;
    end
    check_eq("first_valid_edge", n, 33);
    wait_busy_low(n);
    check_eq("total_edges", n + 33, 170);
    #2;
    for (int i = 0; i < 5; i++) check_eq("basic_word", got[base + i], i + 1);

    // Sign and wrap handling.
    step();
    base = got.size();
    apply_start(32'hFFFF_FFFE, 32'd3329, 32'h7FFF_FFFF, 32'h8000_0000, -32'sd3329, 1'b0, 1'b1);
    wait_busy_low(n);
    #2;
    check_eq("neg2", got[base + 0], 3327);
    check_eq("q_exact", got[base + 1], 0);
    check_eq("max_pos", got[base + 2], 2340);
    check_eq("min_neg", got[base + 3], 988);
    check_eq("neg_q", got[base + 4], 0);

    // Message encoding on the sum word.
    step();
    base = got.size();
    apply_start(32'd10, 32'd20, 32'd30, 32'd40, 32'd2000, 1'b1, 1'b1);
    wait_busy_low(n);
    #2;
    check_eq("msg_2000", got[base + 4], MSG_EN ? 335 : 2000);
    check_eq("msg_col_untouched", got[base + 0], 10);
    step();
    base = got.size();
    apply_start(32'd10, 32'd20, 32'd30, 32'd40, 32'd0, 1'b1, 1'b1);
    wait_busy_low(n);
    #2;
    check_eq("msg_0", got[base + 4], MSG_EN ? 1664 : 0);
    step();
    base = got.size();
    apply_start(32'd10, 32'd20, 32'd30, 32'd40, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_busy_low(n);
    #2;
    check_eq("msg_neg1", got[base + 4], MSG_EN ? 1663 : 3328);

    // Backpressure on word 2, with an ignored start inside the stall.
    step();
    base = got.size();
    apply_start(32'd100, -32'sd100, 32'd7000, -32'sd7000, 32'd123456, 1'b0, 1'b1);
    wait_got(base + 1);
    ct_bus.ct_ready = 1'b0;
    for (int i = 0; i < 100 && !ct_bus.ct_valid; i++) step();
    repeat (3) step();
    apply_start(32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 1'b0, 1'b0);
    repeat (5) step();
    ct_bus.ct_ready = 1'b1;
    wait_busy_low(n);
    #2;
    check_eq("bp_count", got.size() - base, 5);
    check_eq("bp_word2", got[base + 1], 3229);
    repeat (40) step();
    check_eq("bp_no_restart", int'(busy), 0);
    check_eq("bp_queue_empty", exp_data.size(), 0);

    // Reset during REDUCE of word 3.
    base = got.size();
    apply_start(32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 1'b0, 1'b1);
    wait_got(base + 2);
    repeat (10) step();
    rst = 1'b0;
    #1;
    check_eq("mid_rst_data", int'(ct_bus.ct_data), 0);
    check_eq("mid_rst_valid", int'(ct_bus.ct_valid), 0);
    check_eq("mid_rst_last", int'(ct_bus.ct_last), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    exp_data.delete();
    exp_last.delete();
    step();
    step();
    rst = 1'b1;
    step();
    check_eq("post_rst_busy", int'(busy), 0);
    base = got.size();
    apply_start(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 1'b0, 1'b1);
    wait_busy_low(n);
    #2;
    for (int i = 0; i < 5; i++) check_eq("post_rst_word", got[base + i], i + 1);

    // Back-to-back: start in the first cycle after returning to IDLE.
    step();
    base = got.size();
    apply_start(32'd21, 32'd22, 32'd23, 32'd24, 32'd25, 1'b0, 1'b1);
    wait_busy_low(n);
    #1;
    apply_start(-32'sd1, 32'd6658, 32'd3330, -32'sd3330, 32'd77, 1'b0, 1'b1);
    check_eq("b2b_busy", int'(busy), 1);
    wait_busy_low(n);
    #2;
    check_eq("b2b_first_sum", got[base + 4], 25);
    check_eq("b2b_w1", got[base + 5], 3328);
    check_eq("b2b_w2", got[base + 6], 0);
    check_eq("b2b_w3", got[base + 7], 1);
    check_eq("b2b_w4", got[base + 8], 3328);
    check_eq("b2b_sum", got[base + 9], 77);

    check_eq("final_queue_empty", exp_data.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mla_ciphertext_pack.md
# mla_ciphertext_pack

Output stage directly downstream of `mla_accumulator`. On `start` it captures the five signed accumulator results (four cache columns plus the sum stream) and reduces each modulo Q with a bit-serial restoring remainder. It optionally adds the message encoding ⌊Q/2⌋ to the sum word. It streams the five DATA_WIDTH-bit ciphertext words out over a valid/ready interface, ending with `ct_last`.

## Interface
- `DATA_WIDTH`, 12, width of each ciphertext word; Q < 2^DATA_WIDTH.
- `ACC_WIDTH`, 32, width of each accumulator input (two's complement).
- `Q`, 3329, LWE modulus.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start` input 1: pulse; accumulator values are final and must be captured.
- `acc_col1`..`acc_col4` input ACC_WIDTH each: column accumulators, signed.
- `acc_sum` input ACC_WIDTH: sum-stream accumulator, signed.
- `msg_bit` input 1: plaintext bit, sampled with `start`.
- `ct_data` output DATA_WIDTH: reduced word, range 0..Q-1.
- `ct_valid` output 1: `ct_data` is valid.
- `ct_ready` input 1: downstream accepts the word.
- `ct_last` output 1: high with the fifth word (sum).
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states:
  - IDLE
  - REDUCE
  - FIXUP
  - OUT
- IDLE:
  - `start`=1 captures all five accumulators and `msg_bit` into shadow registers.
  - Sets word index to 0, enters REDUCE.
- REDUCE setup for the current word:
  - Magnitude is |value|, formed as an ACC_WIDTH-bit unsigned number, so -2^(ACC_WIDTH-1) gives 2^(ACC_WIDTH-1).
  - Sign bit is saved.
  - Remainder is cleared.
  - Bit counter starts at ACC_WIDTH-1.
- REDUCE, each cycle:
  - rem = (rem<<1) | mag[cnt].
  - If rem ≥ Q, rem -= Q.
  - rem needs DATA_WIDTH+1 bits internally.
  - Exits to FIXUP after the cnt=0 step.
- FIXUP, one cycle:
  - If sign=1 and rem≠0: rem = Q − rem.
  - If word index is 4 and message add is enabled and msg_bit=1: rem += ⌊Q/2⌋, then subtract Q if the result is ≥ Q.
  - Loads `ct_data` and sets `ct_valid`=1.
  - Sets `ct_last` = (index==4).
  - Enters OUT.
- OUT:
  - Holds `ct_data`/`ct_last` stable until `ct_valid`&`ct_ready`.
  - On the handshake: `ct_valid`=0.
  - If `ct_last`, go to IDLE; else increment the index and go to REDUCE with the next word.
- Word order: col1, col2, col3, col4, sum.
- `start` outside IDLE is ignored; the shadow registers are not disturbed.
- Accumulator inputs are don't-care except on the `start` edge.

## Timing
- Reset (`rst`=0, async) forces:
  - state IDLE
  - `ct_data`=0, `ct_valid`=0, `ct_last`=0, `busy`=0
  - all shadow registers and counters 0
- Reset mid-operation discards the ciphertext in progress; no partial stream resumes.
- `busy` rises on the edge that accepts `start`.
- First `ct_valid` is registered on the (ACC_WIDTH+1)th rising edge after the start edge (33 with defaults).
- With `ct_ready` held high, each word costs ACC_WIDTH+2 cycles:
  - ACC_WIDTH REDUCE
  - 1 FIXUP
  - 1 OUT
- Full ciphertext takes 5·(ACC_WIDTH+2) cycles; IDLE is re-entered on the last handshake edge.
- `busy` falls the cycle after the last handshake.
- `ct_ready` may be high before `ct_valid`. `ct_valid` never depends combinationally on `ct_ready`.
- A new `start` is accepted at the earliest one cycle after returning to IDLE.

## Configuration
- `MLA_PACK_MSG_EN` defined:
  - FIXUP adds ⌊Q/2⌋·msg_bit mod Q to the sum word.
- `MLA_PACK_MSG_EN` undefined:
  - The sum word is the plain reduction of `acc_sum`.
  - `msg_bit` is ignored and its register is not implemented; the port stays present.
  - All other behaviour and timing are identical.

## Test plan
- acc = 1,2,3,4, sum=5, msg=0, ready=1:
  - Words 1,2,3,4,5, `ct_last` only on 5.
  - First valid 33 edges after start; `busy` low after word 5.
- Sign and wrap handling:
  - col1=0xFFFFFFFE gives 3327.
  - col2=3329 gives 0.
  - col3=0x7FFFFFFF gives 2340.
  - col4=0x80000000 gives 988.
  - sum=−3329 gives 0.
- With `MLA_PACK_MSG_EN`:
  - sum=2000, msg=1 gives 335.
  - sum=0, msg=1 gives 1664.
  - sum=−1, msg=1 gives 1663.
  - Without the macro, the same cases give 2000, 0, 3328.
- Backpressure: `ct_ready` low for 10 cycles while word 2 is valid.
  - `ct_data`/`ct_valid` stay stable; all five words are delivered once, in order.
  - A `start` pulse during this window is ignored.
- Reset handling:
  - `rst` low during REDUCE of word 3: all outputs 0 immediately, FSM returns to IDLE.
  - A later start with acc = 1..5 yields 1..5 correctly.
- Back-to-back ciphertexts: `start` asserted the cycle after the return to IDLE.
  - The second ciphertext is captured from the new inputs and streams correctly.
